// File: rtl/alu_pkg.sv
// Shared opcode constants, legality check and sequencer state encoding for the
// 64-bit datapath ALU and its operation sequencer.
package alu_pkg;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_LSL   = 4'b0011;
   localparam logic [3:0] OP_LSR   = 4'b0100;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_PASSB = 4'b0111;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      SETTLE_WAIT = 2'd1,
      RESP        = 2'd2
   } seqState_t;

   function automatic logic is_legal_op(input logic [3:0] op);
      logic legal;
      legal = 1'b0;
      case (op)
         OP_AND, OP_OR, OP_ADD, OP_LSL, OP_LSR, OP_SUB, OP_PASSB: legal = 1'b1;
         default:                                                legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/alu_ref_model.sv
// Combinational expected-result model of the ALU, used by the sequencer's
// optional self-check (ALU_SEQ_SELFCHECK_EN).
module alu_ref_model
   import alu_pkg::*;
#(
   parameter int n = 64
) (
   input  logic [3:0]   ALUCtrl,
   input  logic [n-1:0] A,
   input  logic [n-1:0] B,
   output logic [n-1:0] Expected
);

   // Shifts use the full B value, so any amount >= n yields zero.
   always_comb begin
      Expected = '0;
      case (ALUCtrl)
         OP_AND:   Expected = A & B;
         OP_OR:    Expected = A | B;
         OP_ADD:   Expected = A + B;
         OP_LSL:   Expected = A << B;
         OP_LSR:   Expected = A >> B;
         OP_SUB:   Expected = A - B;
         OP_PASSB: Expected = B;
         default:  Expected = '0;
      endcase
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator for the combinational ALU: accepts a request, drives the ALU for a
// fixed settle window, then returns BusW/Zero. Optional checker: ALU_SEQ_SELFCHECK_EN.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int n      = 64,
   parameter int SETTLE = 3
) (
   input  logic         CLK,
   input  logic         Reset,
   input  logic         ReqValid,
   output logic         ReqReady,
   input  logic [3:0]   ReqCtrl,
   input  logic [n-1:0] ReqA,
   input  logic [n-1:0] ReqB,
   output logic [n-1:0] BusA,
   output logic [n-1:0] BusB,
   output logic [3:0]   ALUCtrl,
   input  logic [n-1:0] BusW,
   input  logic         Zero,
   output logic         RspValid,
   input  logic         RspReady,
   output logic [n-1:0] RspResult,
   output logic         RspZero,
   output logic         RspIllegal,
   output logic         RspMismatch
);

   localparam logic [3:0] SettleLoad = 4'(SETTLE - 1);

   seqState_t  state;
   logic [3:0] counter;

   // Decoded from registered state only; RspReady never reaches ReqReady.
   assign ReqReady = (state == IDLE);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; the synchronous reset branch comes first to win.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state      <= IDLE;
         counter    <= '0;
         BusA       <= '0;
         BusB       <= '0;
         ALUCtrl    <= OP_AND;
         RspValid   <= 1'b0;
         RspResult  <= '0;
         RspZero    <= 1'b0;
         RspIllegal <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ReqValid) begin
                  if (is_legal_op(ReqCtrl)) begin
                     BusA    <= ReqA;
                     BusB    <= ReqB;
                     ALUCtrl <= ReqCtrl;
                     counter <= SettleLoad;
                     state   <= SETTLE_WAIT;
                  end else begin
                     // Illegal op never reaches the ALU; answer immediately.
                     RspResult  <= '0;
                     RspZero    <= 1'b0;
                     RspIllegal <= 1'b1;
                     RspValid   <= 1'b1;
                     state      <= RESP;
                  end
               end
            end
            SETTLE_WAIT: begin
               if (counter == 4'd0) begin
                  RspResult  <= BusW;
                  RspZero    <= Zero;
                  RspIllegal <= 1'b0;
                  RspValid   <= 1'b1;
                  state      <= RESP;
               end else begin
                  counter <= counter - 4'd1;
               end
            end
            RESP: begin
               if (RspReady) begin
                  RspValid <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_SEQ_SELFCHECK_EN
   logic [n-1:0] expected;

   alu_ref_model #(.n(n)) uRefModel (
      .ALUCtrl  (ALUCtrl),
      .A        (BusA),
      .B        (BusB),
      .Expected (expected)
   );

   // Flag lives alongside RspValid: set at capture, cleared on handshake.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         RspMismatch <= 1'b0;
      end else if (state == SETTLE_WAIT && counter == 4'd0) begin
         RspMismatch <= (BusW != expected) || (Zero != (BusW == '0));
      end else if (state == IDLE && ReqValid) begin
         RspMismatch <= 1'b0;
      end else if (state == RESP && RspReady) begin
         RspMismatch <= 1'b0;
      end
   end
`else
   assign RspMismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer with a behavioural ALU
// attached; expected values are hand-computed constants.
module tb_alu_op_sequencer;

   localparam int N = 64;

   logic         CLK = 1'b0;
   logic         Reset;
   logic         ReqValid;
   logic         ReqReady;
   logic [3:0]   ReqCtrl;
   logic [N-1:0] ReqA, ReqB;
   logic [N-1:0] BusA, BusB;
   logic [3:0]   ALUCtrl;
   logic [N-1:0] BusW;
   logic         Zero;
   logic         RspValid;
   logic         RspReady;
   logic [N-1:0] RspResult;
   logic         RspZero;
   logic         RspIllegal;
   logic         RspMismatch;

   int compared   = 0;
   int mismatched = 0;

   logic         forceBad = 1'b0;
   logic [N-1:0] aluOut;

   always #5 CLK = ~CLK;

   alu_op_sequencer #(.n(N), .SETTLE(3)) dut (
      .CLK         (CLK),
      .Reset       (Reset),
      .ReqValid    (ReqValid),
      .ReqReady    (ReqReady),
      .ReqCtrl     (ReqCtrl),
      .ReqA        (ReqA),
      .ReqB        (ReqB),
      .BusA        (BusA),
      .BusB        (BusB),
      .ALUCtrl     (ALUCtrl),
      .BusW        (BusW),
      .Zero        (Zero),
      .RspValid    (RspValid),
      .RspReady    (RspReady),
      .RspResult   (RspResult),
      .RspZero     (RspZero),
      .RspIllegal  (RspIllegal),
      .RspMismatch (RspMismatch)
   );

   // Harness ALU; forceBad injects a wrong result for the self-check test.
   always_comb begin
      aluOut = '0;
      case (ALUCtrl)
         4'b0000: aluOut = BusA & BusB;
         4'b0001: aluOut = BusA | BusB;
         4'b0010: aluOut = BusA + BusB;
         4'b0011: aluOut = BusA << BusB;
         4'b0100: aluOut = BusA >> BusB;
         4'b0110: aluOut = BusA - BusB;
         4'b0111: aluOut = BusB;
         default: aluOut = '0;
      endcase
   end
   assign BusW = forceBad ? 64'hFF : aluOut;
   assign Zero = (BusW == '0);

   task automatic check(input string tag, input logic [N-1:0] observed, input logic [N-1:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Accepts one request, returns edges from accept to RspValid and the
   // ALUCtrl seen just after the accept edge. Leaves the response pending.
   task automatic runOp(input logic [3:0] ctrl, input logic [N-1:0] a, input logic [N-1:0] b,
                        output int lat, output logic [3:0] ctrlAfterAccept);
      check("req_ready_before_accept", N'(ReqReady), N'(1));
      ReqCtrl  = ctrl;
      ReqA     = a;
      ReqB     = b;
      ReqValid = 1'b1;
      tick();
      ReqValid = 1'b0;
      ctrlAfterAccept = ALUCtrl;
      lat = 0;
      while (!RspValid && lat < 30) begin
         tick();
         lat++;
      end
   endtask

   task automatic finishRsp();
      RspReady = 1'b1;
      tick();
      check("idle_after_handshake", N'(ReqReady), N'(1));
      check("valid_clear_after_handshake", N'(RspValid), N'(0));
   endtask

   initial begin
      int         lat;
      logic [3:0] ctrlSeen;

      Reset    = 1'b1;
      ReqValid = 1'b0;
      ReqCtrl  = 4'b0000;
      ReqA     = '0;
      ReqB     = '0;
      RspReady = 1'b1;
      tick();
      tick();
      check("rst_req_ready", N'(ReqReady), N'(1));
      check("rst_rsp_valid", N'(RspValid), N'(0));
      check("rst_bus_a", BusA, '0);
      check("rst_bus_b", BusB, '0);
      check("rst_alu_ctrl", N'(ALUCtrl), N'(0));
      check("rst_rsp_result", RspResult, '0);
      check("rst_rsp_flags", N'({RspZero, RspIllegal, RspMismatch}), N'(0));
      Reset = 1'b0;
      tick();

      // Basic ADD 5 + 7
      runOp(4'b0010, 64'd5, 64'd7, lat, ctrlSeen);
      check("add_ctrl_after_accept", N'(ctrlSeen), N'(4'b0010));
      check("add_latency", N'(lat), N'(3));
      check("add_result", RspResult, 64'd12);
      check("add_zero", N'(RspZero), N'(0));
      check("add_illegal", N'(RspIllegal), N'(0));
      finishRsp();

      // SUB to zero
      runOp(4'b0110, 64'h1234, 64'h1234, lat, ctrlSeen);
      check("sub_latency", N'(lat), N'(3));
      check("sub_result", RspResult, '0);
      check("sub_zero", N'(RspZero), N'(1));
      check("sub_illegal", N'(RspIllegal), N'(0));
      finishRsp();

      // Illegal opcode 0101: immediate response, ALU outputs untouched
      runOp(4'b0101, 64'd1, 64'd1, lat, ctrlSeen);
      check("ill_latency", N'(lat), N'(0));
      check("ill_flag", N'(RspIllegal), N'(1));
      check("ill_result", RspResult, '0);
      check("ill_zero", N'(RspZero), N'(0));
      check("ill_alu_ctrl_kept", N'(ALUCtrl), N'(4'b0110));
      check("ill_bus_a_kept", BusA, 64'h1234);
      finishRsp();

      // A few more opcodes
      runOp(4'b0001, 64'hF0, 64'h0F, lat, ctrlSeen);
      check("or_result", RspResult, 64'hFF);
      finishRsp();
      runOp(4'b0100, 64'h100, 64'd4, lat, ctrlSeen);
      check("lsr_result", RspResult, 64'h10);
      finishRsp();
      runOp(4'b0111, 64'd1, 64'hABCD, lat, ctrlSeen);
      check("passb_result", RspResult, 64'hABCD);
      finishRsp();
      runOp(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, lat, ctrlSeen);
      check("add_wrap_result", RspResult, '0);
      check("add_wrap_zero", N'(RspZero), N'(1));
      finishRsp();

      // Backpressure: LSL 1 << 4 held for 10 cycles
      RspReady = 1'b0;
      runOp(4'b0011, 64'd1, 64'd4, lat, ctrlSeen);
      check("lsl_latency", N'(lat), N'(3));
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", N'(RspValid), N'(1));
         check("bp_result", RspResult, 64'd16);
         check("bp_req_ready", N'(ReqReady), N'(0));
         tick();
      end
      finishRsp();

      // Reset during SETTLE_WAIT drops the op
      runOp(4'b0010, 64'd9, 64'd9, lat, ctrlSeen);
      finishRsp();
      ReqCtrl  = 4'b0010;
      ReqA     = 64'd3;
      ReqB     = 64'd4;
      ReqValid = 1'b1;
      tick();
      ReqValid = 1'b0;
      check("mid_in_settle", N'(ReqReady), N'(0));
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check("mid_rst_idle", N'(ReqReady), N'(1));
      check("mid_rst_valid", N'(RspValid), N'(0));
      check("mid_rst_bus_a", BusA, '0);
      check("mid_rst_bus_b", BusB, '0);
      check("mid_rst_alu_ctrl", N'(ALUCtrl), N'(0));
      for (int i = 0; i < 6; i++) begin
         tick();
         check("mid_no_response", N'(RspValid), N'(0));
      end

      // Self-check: correct ALU, then a corrupted BusW on AND F0 & 0F
      runOp(4'b0000, 64'hF0, 64'h0F, lat, ctrlSeen);
      check("and_result", RspResult, '0);
      check("and_zero", N'(RspZero), N'(1));
      check("and_mismatch_clean", N'(RspMismatch), N'(0));
      finishRsp();
      forceBad = 1'b1;
      runOp(4'b0000, 64'hF0, 64'h0F, lat, ctrlSeen);
      check("bad_result_captured", RspResult, 64'hFF);
`ifdef ALU_SEQ_SELFCHECK_EN
      check("bad_mismatch_flag", N'(RspMismatch), N'(1));
`else
      check("bad_mismatch_tied_low", N'(RspMismatch), N'(0));
`endif
      finishRsp();
      forceBad = 1'b0;
      check("mismatch_cleared", N'(RspMismatch), N'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
